// File: rtl/toggle_counter_pkg.sv
// Shared constants for the toggle counter: direction encoding and default sizing.
package toggle_counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int unsigned DEFAULT_WIDTH = 4;

   // Largest value representable in w bits, safe for w = 32.
   function automatic int unsigned max_count_of(input int unsigned w);
      if (w >= 32) begin
         return 32'hFFFF_FFFF;
      end
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/t_ff_bit.sv
// Single toggle cell: synchronous active-low reset, direct load, otherwise toggle on request.
module t_ff_bit (
   input  logic clk,
   input  logic reset,
   input  logic tog,
   input  logic ld,
   input  logic ld_val,
   output logic q
);

   logic q_q;
   logic q_d;

   // Load overrides toggle; hold when neither is requested.
   always_comb begin
      q_d = q_q;
      if (ld) begin
         q_d = ld_val;
      end else if (tog) begin
         q_d = ~q_q;
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/toggle_counter.sv
// Up/down counter built from toggle cells, with modulo wrap at MAX_COUNT,
// clamped synchronous load and a registered one-cycle terminal-count pulse.
module toggle_counter
   import toggle_counter_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter int unsigned MAX_COUNT = max_count_of(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc
);

   localparam logic [WIDTH-1:0] MaxQ = MAX_COUNT[WIDTH-1:0];

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] tog;
   logic [WIDTH-1:0] ld_next;
   logic             ld;
   logic             wrap_up;
   logic             wrap_dn;
   logic             run_ones;
   logic             run_zeros;
   logic             tc_d;
   logic             tc_q;

   // Per-bit toggle requests: up flips a bit when all lower bits are 1, down when all are 0.
   always_comb begin
      tog       = '0;
      run_ones  = 1'b1;
      run_zeros = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         tog[i]    = en & ((up_dn == DIR_UP) ? run_ones : run_zeros);
         run_ones  = run_ones & cnt[i];
         run_zeros = run_zeros & ~cnt[i];
      end
   end

   // Wrap and load bypass the toggle path with a direct next value; load has priority.
   always_comb begin
      wrap_up = en & (up_dn == DIR_UP) & (cnt == MaxQ);
      wrap_dn = en & (up_dn == DIR_DOWN) & (cnt == '0);
      ld      = 1'b0;
      ld_next = '0;
      if (load) begin
         ld      = 1'b1;
         ld_next = (load_val > MaxQ) ? MaxQ : load_val;
      end else if (wrap_up) begin
         ld      = 1'b1;
         ld_next = '0;
      end else if (wrap_dn) begin
         ld      = 1'b1;
         ld_next = MaxQ;
      end
   end

   // A load in the same cycle cancels the wrap, so no pulse.
   always_comb begin
      tc_d = ~load & (wrap_up | wrap_dn);
   end

   // Terminal-count pulse register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tc_q <= 1'b0;
      end else begin
         tc_q <= tc_d;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      t_ff_bit u_bit (
         .clk    (clk),
         .reset  (reset),
         .tog    (tog[i]),
         .ld     (ld),
         .ld_val (ld_next[i]),
         .q      (cnt[i])
      );
   end

   assign q  = cnt;
   assign tc = tc_q;

endmodule

// File: tb/tb_toggle_counter.sv
// Self-checking bench: two counter instances (4-bit mod-10, 8-bit full range) against
// an arithmetic reference model, plus directed literal scenarios.
module tb_toggle_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       up_dn;
   logic       load;
   logic [3:0] lv4;
   logic [7:0] lv8;
   logic [3:0] q4;
   logic       tc4;
   logic [7:0] q8;
   logic       tc8;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   toggle_counter #(
      .WIDTH     (4),
      .MAX_COUNT (9)
   ) dut4 (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .up_dn    (up_dn),
      .load     (load),
      .load_val (lv4),
      .q        (q4),
      .tc       (tc4)
   );

   toggle_counter #(
      .WIDTH     (8),
      .MAX_COUNT (255)
   ) dut8 (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .up_dn    (up_dn),
      .load     (load),
      .load_val (lv8),
      .q        (q8),
      .tc       (tc8)
   );

   // Reference model: plain modulo arithmetic from the priority rules.
   function automatic int unsigned next_q(input int unsigned cur, input int unsigned mx,
                                          input bit r, input bit e, input bit u, input bit l,
                                          input int unsigned lv);
      if (!r) return 0;
      if (l) return (lv > mx) ? mx : lv;
      if (e) begin
         if (u) return (cur == mx) ? 0 : cur + 1;
         return (cur == 0) ? mx : cur - 1;
      end
      return cur;
   endfunction

   function automatic bit next_tc(input int unsigned cur, input int unsigned mx,
                                  input bit r, input bit e, input bit u, input bit l);
      if (!r || l || !e) return 1'b0;
      return u ? (cur == mx) : (cur == 0);
   endfunction

   int unsigned m_q  [2];
   bit          m_tc [2];
   int unsigned n_q  [2];
   bit          n_tc [2];
   bit          m_valid = 1'b0;

   always_comb begin
      n_q[0]  = next_q(m_q[0], 9, reset, en, up_dn, load, 32'(lv4));
      n_tc[0] = next_tc(m_q[0], 9, reset, en, up_dn, load);
      n_q[1]  = next_q(m_q[1], 255, reset, en, up_dn, load, 32'(lv8));
      n_tc[1] = next_tc(m_q[1], 255, reset, en, up_dn, load);
   end

   always @(posedge clk) begin
      m_q[0]  <= n_q[0];
      m_tc[0] <= n_tc[0];
      m_q[1]  <= n_q[1];
      m_tc[1] <= n_tc[1];
      if (!reset) m_valid <= 1'b1;
   end

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, then compare both DUTs with the model on the falling edge.
   task automatic cyc(input bit r, input bit e, input bit u, input bit l,
                      input logic [3:0] v4, input logic [7:0] v8);
      reset = r;
      en    = e;
      up_dn = u;
      load  = l;
      lv4   = v4;
      lv8   = v8;
      @(negedge clk);
      if (m_valid) begin
         chk("model_q4", 32'(q4), m_q[0]);
         chk("model_tc4", 32'(tc4), 32'(m_tc[0]));
         chk("model_q8", 32'(q8), m_q[1]);
         chk("model_tc8", 32'(tc8), 32'(m_tc[1]));
      end
   endtask

   initial begin
      int exp_up [12];
      int exp_dn [4];
      exp_up = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      exp_dn = '{1, 0, 9, 8};

      // Reset dominates load and enable.
      for (int k = 0; k < 2; k++) begin
         cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 8'd5);
         chk("reset_q", 32'(q4), 0);
         chk("reset_tc", 32'(tc4), 0);
      end

      // Up count through the mod-10 wrap.
      for (int k = 0; k < 12; k++) begin
         cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0);
         chk("up_q", 32'(q4), 32'(exp_up[k]));
         chk("up_tc", 32'(tc4), (k == 9) ? 1 : 0);
      end

      // Down count from 2 through the underflow wrap.
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 8'd0);
      chk("load2_q", 32'(q4), 2);
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
         chk("dn_q", 32'(q4), 32'(exp_dn[k]));
         chk("dn_tc", 32'(tc4), (k == 2) ? 1 : 0);
      end

      // Clamped load, then wrap from the clamped value.
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'd14, 8'd0);
      chk("clamp_q", 32'(q4), 9);
      chk("clamp_tc", 32'(tc4), 0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0);
      chk("clamp_wrap_q", 32'(q4), 0);
      chk("clamp_wrap_tc", 32'(tc4), 1);

      // Load wins over a would-be wrap.
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'd9, 8'd0);
      chk("preload9_q", 32'(q4), 9);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 8'd0);
      chk("load_vs_wrap_q", 32'(q4), 3);
      chk("load_vs_wrap_tc", 32'(tc4), 0);

      // Full-range 8-bit: natural overflow, then mid-count reset.
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 8'd255);
      chk("w8_load_q", 32'(q8), 255);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0);
      chk("w8_wrap_q", 32'(q8), 0);
      chk("w8_wrap_tc", 32'(tc8), 1);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 8'd126);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0);
      chk("w8_mid_q", 32'(q8), 128);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0);
      chk("w8_reset_q", 32'(q8), 0);
      chk("w8_reset_tc", 32'(tc8), 0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0);
      chk("w8_first_after_reset_q", 32'(q8), 1);

      // Randomized traffic, checked against the model every cycle.
      for (int k = 0; k < 3000; k++) begin
         cyc(($urandom_range(0, 49) != 0),
             ($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0),
             4'($urandom_range(0, 15)),
             8'($urandom_range(0, 255)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
